// File: rtl/sa_result_drain_if.sv
// rtl/sa_result_drain_if.sv - result stream bundle between the drain and its consumer
// Carries one column result per beat, tagged with column index, tile number and last flag.
interface sa_result_drain_if #(
   parameter int ROWS     = 8,
   parameter int OUTWIDTH = 32,
   parameter int TAGW     = 8
);
   localparam int COLW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [OUTWIDTH-1:0] m_data;
   logic [COLW-1:0]     m_col;
   logic [TAGW-1:0]     m_tile;
   logic                m_last;
   logic                m_valid;
   logic                m_ready;

   modport master (
      output m_data,
      output m_col,
      output m_tile,
      output m_last,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_col,
      input  m_tile,
      input  m_last,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - captures a full systolic tile and serialises it one column per beat
// Capture releases the core immediately, so the next tile can be taken on the final beat.
module sa_result_drain #(
   parameter int ROWS     = 8,
   parameter int OUTWIDTH = 32,
   parameter int TAGW     = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [OUTWIDTH-1:0] in_r [0:ROWS-1],
   input  logic [ROWS-1:0]     in_v,
   output logic                rread,
   output logic                busy,
   sa_result_drain_if.master   m
);
   localparam int              COLW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [COLW-1:0] LAST_K = COLW'(ROWS - 1);

   typedef enum logic {EMPTY, STREAM} state_t;

   state_t              state_q, state_d;
   logic [COLW-1:0]     k_q, k_d;
   logic [OUTWIDTH-1:0] tile_buf [0:ROWS-1];
   logic [TAGW-1:0]     cnt_q;
   logic [TAGW-1:0]     tag_q;
   logic                streaming;
   logic                fire;
   logic                last_fire;
   logic                capture;

   assign streaming = (state_q == STREAM);
   assign fire      = streaming && m.m_ready;
   assign last_fire = fire && (k_q == LAST_K);
   // rread blocks capture so the core's stale in_v during its acknowledge cycle is ignored
   assign capture   = (&in_v) && !rread && ((state_q == EMPTY) || last_fire);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         EMPTY: begin
            if (capture) begin
               state_d = STREAM;
               k_d     = '0;
            end
         end
         STREAM: begin
            if (capture) begin
               state_d = STREAM;
               k_d     = '0;
            end else if (last_fire) begin
               state_d = EMPTY;
               k_d     = '0;
            end else if (fire) begin
               k_d = k_q + COLW'(1);
            end
         end
         default: begin
            state_d = EMPTY;
            k_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         k_q     <= '0;
         rread   <= 1'b0;
         cnt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         rread   <= capture;
         if (capture) begin
            tag_q <= cnt_q;
            cnt_q <= cnt_q + TAGW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ROWS; i++) tile_buf[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < ROWS; i++) tile_buf[i] <= in_r[i];
      end
   end

   assign m.m_valid = streaming;
   assign m.m_data  = streaming ? tile_buf[k_q] : '0;
   assign m.m_col   = k_q;
   assign m.m_tile  = tag_q;
   assign m.m_last  = streaming && (k_q == LAST_K);
   assign busy      = streaming;
endmodule

// File: tb/tb_sa_result_drain.sv
// tb/tb_sa_result_drain.sv - directed self-checking bench for sa_result_drain
// Four columns and a 2-bit tile tag so the tag wrap is reached within a few tiles.
module tb_sa_result_drain;
   localparam int ROWS     = 4;
   localparam int OUTWIDTH = 32;
   localparam int TAGW     = 2;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [OUTWIDTH-1:0] in_r [0:ROWS-1];
   logic [ROWS-1:0]     in_v = '0;
   logic                rread;
   logic                busy;
   int                  errors = 0;
   int                  checks = 0;

   sa_result_drain_if #(.ROWS(ROWS), .OUTWIDTH(OUTWIDTH), .TAGW(TAGW)) bus ();

   sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(OUTWIDTH), .TAGW(TAGW)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .in_r  (in_r),
      .in_v  (in_v),
      .rread (rread),
      .busy  (busy),
      .m     (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input int b, input int c, input int d);
      in_r[0] = a; in_r[1] = b; in_r[2] = c; in_r[3] = d;
   endtask

   // Checks one visible beat; the caller has already set m_ready for this cycle
   task automatic beat(input string tag, input int col, input int data, input int tile);
      chk({tag, "_valid"}, bus.m_valid, 1);
      chk({tag, "_col"},   bus.m_col,   col);
      chk({tag, "_data"},  bus.m_data,  data);
      chk({tag, "_tile"},  bus.m_tile,  tile);
      chk({tag, "_last"},  bus.m_last,  (col == ROWS - 1) ? 1 : 0);
   endtask

   initial begin
      bus.m_ready = 1'b1;
      load(0, 0, 0, 0);
      #1;
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_rread", rread, 0);
      chk("rst_data",  bus.m_data, 0);
      chk("rst_tile",  bus.m_tile, 0);
      step();
      rstn = 1'b1;
      step(); step();

      // Single tile, ready high; in_v held through the rread cycle is stale
      load(10, 20, 30, 40);
      in_v = 4'b1111;
      chk("t1_pre_valid", bus.m_valid, 0);
      step();
      chk("t1_rread", rread, 1);
      beat("t1_b0", 0, 10, 0);
      step();
      in_v = 4'b0000;
      chk("t1_stale_rread", rread, 0);
      beat("t1_b1", 1, 20, 0);
      step();
      chk("t1_rread_b2", rread, 0);
      beat("t1_b2", 2, 30, 0);
      step();
      beat("t1_b3", 3, 40, 0);
      step();
      chk("t1_end_valid", bus.m_valid, 0);
      chk("t1_end_busy",  busy, 0);
      chk("t1_end_last",  bus.m_last, 0);

      // Backpressure on beat 0 for three cycles
      bus.m_ready = 1'b0;
      load(11, 21, 31, 41);
      in_v = 4'b1111;
      step();
      in_v = 4'b0000;
      chk("bp_rread", rread, 1);
      beat("bp_hold0", 0, 11, 1);
      step();
      chk("bp_rread_once", rread, 0);
      beat("bp_hold1", 0, 11, 1);
      step();
      beat("bp_hold2", 0, 11, 1);
      bus.m_ready = 1'b1;
      step();
      beat("bp_b1", 1, 21, 1);
      step();
      beat("bp_b2", 2, 31, 1);
      step();
      beat("bp_b3", 3, 41, 1);
      step();
      chk("bp_end_valid", bus.m_valid, 0);

      // Partial valid never captures
      load(12, 22, 32, 42);
      in_v = 4'b1110;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("pv_rread", rread, 0);
         chk("pv_valid", bus.m_valid, 0);
      end
      in_v = 4'b1111;
      step();
      in_v = 4'b0000;
      chk("pv_rread_cap", rread, 1);
      beat("pv_b0", 0, 12, 2);
      step(); beat("pv_b1", 1, 22, 2);
      step(); beat("pv_b2", 2, 32, 2);
      step(); beat("pv_b3", 3, 42, 2);
      step();
      chk("pv_end_valid", bus.m_valid, 0);

      // Back-to-back: next tile valid on the final beat; tag wraps 3 -> 0
      load(13, 23, 33, 43);
      in_v = 4'b1111;
      step();
      in_v = 4'b0000;
      chk("bb_rread_a", rread, 1);
      beat("bb_a0", 0, 13, 3);
      step(); beat("bb_a1", 1, 23, 3);
      chk("bb_rread_a_once", rread, 0);
      step(); beat("bb_a2", 2, 33, 3);
      step(); beat("bb_a3", 3, 43, 3);
      load(14, 24, 34, 44);
      in_v = 4'b1111;
      step();
      chk("bb_rread_b", rread, 1);
      beat("bb_b0", 0, 14, 0);
      in_v = 4'b0000;
      step(); beat("bb_b1", 1, 24, 0);
      chk("bb_rread_b_once", rread, 0);
      step(); beat("bb_b2", 2, 34, 0);
      step(); beat("bb_b3", 3, 44, 0);
      step();
      chk("bb_end_valid", bus.m_valid, 0);

      // Reset mid-stream at beat 2
      load(15, 25, 35, 45);
      in_v = 4'b1111;
      step();
      in_v = 4'b0000;
      beat("rs_b0", 0, 15, 1);
      step();
      step();
      beat("rs_b2", 2, 35, 1);
      #1;
      rstn = 1'b0;
      #1;
      chk("rs_async_valid", bus.m_valid, 0);
      chk("rs_async_busy",  busy, 0);
      chk("rs_async_tile",  bus.m_tile, 0);
      chk("rs_async_data",  bus.m_data, 0);
      step();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rs_idle_valid", bus.m_valid, 0);
         chk("rs_idle_rread", rread, 0);
      end
      load(16, 26, 36, 46);
      in_v = 4'b1111;
      step();
      in_v = 4'b0000;
      chk("rs_new_rread", rread, 1);
      beat("rs_new_b0", 0, 16, 0);
      step(); beat("rs_new_b1", 1, 26, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
